ycell_core: RTL and testbench
=============================

// Module: ycell_core
// PURPOSE
//  Configurable Morphle Logic "yellow cell"; one tile of a 2-D array, wired to U/D/L/R neighbours.
//  - 3-bit config word shifted in serially along a per-column chain (cbitin -> cbitout).
//  - Selects space / wire / crossing / constant source / match cell.
//  - Signals are dual-rail, 2 bits: 00=null, 01=logic 0, 10=logic 1, 11=illegal.
// PARAMETERS
//  CFGW  3  config word width; encodings below assume 3
// PORTS
//  clk      in   1  system clock; all state updates on rising edge
//  reset    in   1  synchronous, active-high; clears config and FSM state
//  confclk  in   1  config shift strobe, sampled on clk (level: shift once per clk while high)
//  cbitin   in   1  serial config bit from cell U
//  cbitout  out  1  serial config bit to cell D (= cfg[2])
//  hempty   out  1  1 = cell breaks horizontal signals
//  vempty   out  1  1 = cell breaks vertical signals
//  uempty   in   1  neighbour U empty; forces uout=00
//  dempty   in   1  neighbour D empty; forces dout=00
//  lempty   in   1  neighbour L empty; forces lout=00
//  rempty   in   1  neighbour R empty; forces rout=00
//  uin/din/lin/rin      in   2  dual-rail values from U/D/L/R
//  uout/dout/lout/rout  out  2  dual-rail values to U/D/L/R
// BEHAVIOUR
//  - Config shift: reset -> cfg=000; elsif confclk: cfg <= {cfg[1:0],cbitin}.
//  - cbitout = cfg[2] (registered; 3-clk delay through the cell).
//  - Encodings:
//    000 space: hempty=vempty=1.
//    001 '+': H and V both pass, independently.
//    010 '-': H passes; vempty=1.
//    011 '|': V passes; hempty=1.
//    100 '1': V pass; local vdrv=10 gated by hfsm.
//    101 '0': V pass; local vdrv=01 gated by hfsm.
//    110 'Y': H gated by vin==10.
//    111 'N': H gated by vin==01.
//  - Pass-through (V, when not vempty):
//    dout = uin | vdrv;  uout = din | vdrv.
//    vin  = uin | din   (for match).
//  - Pass-through (H, when not hempty):
//    rout = lin | hdrv;  lout = rin | hdrv.
//    hin  = lin | rin.
//  - Blocked direction, or corresponding neighbour *empty=1: that output = 00.
//  - In Y/N, H is not passed combinationally: hdrv = fsm output, lin/rin not ORed in.
//  - Match FSM (one per cell; clk registered, reset -> IDLE, output 00). Input hin; match per cfg.
//    - IDLE -> PASS when hin!=00 && match (Y/N); for 1/0, match = (hin!=00).
//    - PASS: output = hin (Y/N) or the constant (1/0).
//    - PASS -> IDLE when hin==00; match changes while in PASS are ignored (4-phase hold).
//  - Output latency: hin/vin to gated output = 1 clk; pure wire paths combinational.
//  - hin or vin == 11: treated as non-null but never matches; passthrough ORs bits unchanged.
//  - Reset mid-operation: cfg=000 immediately after the edge, so all outputs 00, hempty=vempty=1.
// CONFIGURATION
//  YCELL_OUT_REG_EN
//    - defined: all eight data outputs plus hempty/vempty registered; +1 clk on every path.
//    - undefined: wire paths combinational, as above.
// STRUCTURE
//  - Package ycell_pkg: cfg encoding localparams (CFG_SPACE..CFG_N), dual-rail constants
//    DR_NULL/DR_0/DR_1/DR_BAD, FSM state enum.
//  - One sub-module ycell_fsm (in[1:0], match, const sel -> out[1:0]); the rest flat in ycell_core.
// TESTING
//  Bench vector: 26 bits; first 7 vectors ignored (settle); reset=X ends run.
//    {xhempty,xvempty, uempty,dempty,lempty,rempty, reset,confclk,cbitin,xcbitout,
//     uin,xuout, din,xdout, lin,xlout, rin,xrout}
//  1 reset=1 any inputs -> cbitout=0, hempty=vempty=1, all outs 00.
//  2 shift 0,1,1 with confclk ('|') -> vempty=0,hempty=1; uin=10 -> dout=10; din=01 -> uout=01; lin=10 -> rout=00.
//  3 cfg '-', lin=01, rempty=1 -> rout=00; rempty=0 -> rout=01, uout=dout=00.
//  4 cfg 'Y':
//    - uin=10, lin=01 -> next clk rout=01,lout=01.
//    - uin=01 meanwhile -> rout holds 01.
//    - lin=00 -> next clk rout=00.
//  5 cfg 'N', uin=10, lin=10 -> rout stays 00; uin=01 -> next clk rout=10.
//  6 cfg '1', lin=01 -> next clk dout=uout=10; lin=00 -> next clk 00; shift 3 more bits -> cbitout replays 1,0,0.

Source files
------------

// File: rtl/ycell_pkg.sv
// Shared definitions for the Morphle Logic yellow cell: config encodings,
// dual-rail signal constants and the match FSM state type.
package ycell_pkg;

    localparam logic [2:0] CFG_SPACE = 3'b000;
    localparam logic [2:0] CFG_CROSS = 3'b001;
    localparam logic [2:0] CFG_HWIRE = 3'b010;
    localparam logic [2:0] CFG_VWIRE = 3'b011;
    localparam logic [2:0] CFG_ONE   = 3'b100;
    localparam logic [2:0] CFG_ZERO  = 3'b101;
    localparam logic [2:0] CFG_Y     = 3'b110;
    localparam logic [2:0] CFG_N     = 3'b111;

    localparam logic [1:0] DR_NULL = 2'b00;
    localparam logic [1:0] DR_0    = 2'b01;
    localparam logic [1:0] DR_1    = 2'b10;
    localparam logic [1:0] DR_BAD  = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PASS = 1'b1
    } fsm_state_t;

    // Only a clean logic 0 or logic 1 may trigger a match; 11 never does.
    function automatic logic dr_valid(input logic [1:0] v);
        return (v == DR_0) || (v == DR_1);
    endfunction

endpackage

// File: rtl/ycell_fsm.sv
// Four-phase match FSM: latches onto a non-null input that matches, then holds
// until the input returns to null. Output is registered (one clock latency).
module ycell_fsm
    import ycell_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] sig_in,
    input  logic       match,
    input  logic       const_sel,
    input  logic [1:0] const_val,
    output logic [1:0] sig_out,
    output fsm_state_t state
);

    fsm_state_t state_next;
    logic [1:0] out_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            sig_out <= DR_NULL;
        end else begin
            state   <= state_next;
            sig_out <= out_next;
        end
    end

    // Match is only consulted from IDLE; once in PASS only the return to null matters.
    always_comb begin
        state_next = state;
        out_next   = DR_NULL;
        case (state)
            ST_IDLE: if ((sig_in != DR_NULL) && match) state_next = ST_PASS;
            ST_PASS: if (sig_in == DR_NULL) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
        if (state_next == ST_PASS) out_next = const_sel ? const_val : sig_in;
    end

endmodule

// File: rtl/ycell_core.sv
// Morphle Logic yellow cell: serially configured tile of space/wire/crossing/
// constant/match behaviour. Define YCELL_OUT_REG_EN to register all outputs.
module ycell_core
    import ycell_pkg::*;
#(
    parameter int CFGW = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       confclk,
    input  logic       cbitin,
    output logic       cbitout,
    output logic       hempty,
    output logic       vempty,
    input  logic       uempty,
    input  logic       dempty,
    input  logic       lempty,
    input  logic       rempty,
    input  logic [1:0] uin,
    input  logic [1:0] din,
    input  logic [1:0] lin,
    input  logic [1:0] rin,
    output logic [1:0] uout,
    output logic [1:0] dout,
    output logic [1:0] lout,
    output logic [1:0] rout
);

    logic [CFGW-1:0] cfg;

    always_ff @(posedge clk) begin
        if (reset)        cfg <= '0;
        else if (confclk) cfg <= {cfg[CFGW-2:0], cbitin};
    end

    assign cbitout = cfg[CFGW-1];

    logic h_pass, v_pass, h_gate, v_const;
    logic match;
    logic [1:0] hin, vin, const_val, fsm_out, gated, vdrv;
    fsm_state_t match_state;

    always_comb begin
        h_pass  = 1'b0;
        v_pass  = 1'b0;
        h_gate  = 1'b0;
        v_const = 1'b0;
        case (cfg[2:0])
            CFG_CROSS:         begin h_pass = 1'b1; v_pass = 1'b1; end
            CFG_HWIRE:         h_pass = 1'b1;
            CFG_VWIRE:         v_pass = 1'b1;
            CFG_ONE, CFG_ZERO: begin v_pass = 1'b1; v_const = 1'b1; end
            CFG_Y, CFG_N:      begin v_pass = 1'b1; h_gate = 1'b1; end
            default:           ;
        endcase
    end

    assign hin       = lin | rin;
    assign vin       = uin | din;
    assign const_val = (cfg[2:0] == CFG_ONE) ? DR_1 : DR_0;

    always_comb begin
        match = 1'b0;
        case (cfg[2:0])
            CFG_Y:             match = (vin == DR_1) && dr_valid(hin);
            CFG_N:             match = (vin == DR_0) && dr_valid(hin);
            CFG_ONE, CFG_ZERO: match = dr_valid(hin);
            default:           match = 1'b0;
        endcase
    end

    ycell_fsm u_fsm (
        .clk       (clk),
        .reset     (reset),
        .sig_in    (hin),
        .match     (match),
        .const_sel (v_const),
        .const_val (const_val),
        .sig_out   (fsm_out),
        .state     (match_state)
    );

    assign gated = (match_state == ST_PASS) ? fsm_out : DR_NULL;
    assign vdrv  = v_const ? gated : DR_NULL;

    logic [1:0] u_nx, d_nx, l_nx, r_nx;
    logic       hempty_nx, vempty_nx;

    // 1/0 cells consume the horizontal signal as a trigger and drive nothing sideways.
    always_comb begin
        u_nx = (v_pass && !uempty) ? (din | vdrv) : DR_NULL;
        d_nx = (v_pass && !dempty) ? (uin | vdrv) : DR_NULL;
        l_nx = DR_NULL;
        r_nx = DR_NULL;
        if (h_pass) begin
            l_nx = rin;
            r_nx = lin;
        end else if (h_gate) begin
            l_nx = gated;
            r_nx = gated;
        end
        if (lempty) l_nx = DR_NULL;
        if (rempty) r_nx = DR_NULL;
    end

    assign hempty_nx = !(h_pass || h_gate || v_const);
    assign vempty_nx = !v_pass;

`ifdef YCELL_OUT_REG_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            uout   <= DR_NULL;
            dout   <= DR_NULL;
            lout   <= DR_NULL;
            rout   <= DR_NULL;
            hempty <= 1'b1;
            vempty <= 1'b1;
        end else begin
            uout   <= u_nx;
            dout   <= d_nx;
            lout   <= l_nx;
            rout   <= r_nx;
            hempty <= hempty_nx;
            vempty <= vempty_nx;
        end
    end
`else
    assign uout   = u_nx;
    assign dout   = d_nx;
    assign lout   = l_nx;
    assign rout   = r_nx;
    assign hempty = hempty_nx;
    assign vempty = vempty_nx;
`endif

endmodule

// File: tb/tb_ycell_core.sv
// Bench for ycell_core (default build): vector table, directed multi-cycle
// sequences, and randomized stimulus against a behavioural cell model.
module tb_ycell_core;

    logic clk = 1'b0;
    logic reset, confclk, cbitin, cbitout, hempty, vempty;
    logic uempty, dempty, lempty, rempty;
    logic [1:0] uin, din, lin, rin, uout, dout, lout, rout;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ycell_core dut (
        .clk(clk), .reset(reset), .confclk(confclk), .cbitin(cbitin), .cbitout(cbitout),
        .hempty(hempty), .vempty(vempty),
        .uempty(uempty), .dempty(dempty), .lempty(lempty), .rempty(rempty),
        .uin(uin), .din(din), .lin(lin), .rin(rin),
        .uout(uout), .dout(dout), .lout(lout), .rout(rout)
    );

    typedef struct {
        logic [2:0] cfg;
        logic [3:0] emp;                  // {u,d,l,r}
        logic [1:0] ui, di, li, ri;
        logic [1:0] xu, xd, xl, xr;
        logic       xh, xv;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic null_inputs();
        uin = 2'b00; din = 2'b00; lin = 2'b00; rin = 2'b00;
        uempty = 1'b0; dempty = 1'b0; lempty = 1'b0; rempty = 1'b0;
    endtask

    task automatic shift_cfg(input logic [2:0] c);
        null_inputs();
        for (int i = 2; i >= 0; i--) begin
            confclk = 1'b1;
            cbitin  = c[i];
            tick();
        end
        confclk = 1'b0;
        cbitin  = 1'b0;
        #1;
    endtask

    task automatic check_all(input string tag, input logic [1:0] xu, xd, xl, xr,
                             input logic xh, xv);
        check({tag, ".uout"}, 8'(uout), 8'(xu));
        check({tag, ".dout"}, 8'(dout), 8'(xd));
        check({tag, ".lout"}, 8'(lout), 8'(xl));
        check({tag, ".rout"}, 8'(rout), 8'(xr));
        check({tag, ".hempty"}, 8'(hempty), 8'(xh));
        check({tag, ".vempty"}, 8'(vempty), 8'(xv));
    endtask

    // Behavioural model state: whether the cell is holding a gated value, and that value.
    logic       m_busy;
    logic [1:0] m_g;

    function automatic logic [1:0] rand_dr();
        int r = $urandom_range(0, 99);
        if (r < 40) return 2'b00;
        if (r < 65) return 2'b01;
        if (r < 90) return 2'b10;
        return 2'b11;
    endfunction

    task automatic random_block(input logic [2:0] c, input int cycles);
        logic h_thru, v_thru, gate_h, konst;
        logic [1:0] vdrv, hin, vin, ex_u, ex_d, ex_l, ex_r;
        logic ok_h, m;
        shift_cfg(c);
        m_busy = 1'b0;
        m_g    = 2'b00;
        h_thru = (c == 3'd1) || (c == 3'd2);
        v_thru = (c == 3'd1) || (c >= 3'd3);
        gate_h = (c == 3'd6) || (c == 3'd7);
        konst  = (c == 3'd4) || (c == 3'd5);
        for (int k = 0; k < cycles; k++) begin
            uin = rand_dr(); din = rand_dr(); lin = rand_dr(); rin = rand_dr();
            uempty = ($urandom_range(0, 9) == 0);
            dempty = ($urandom_range(0, 9) == 0);
            lempty = ($urandom_range(0, 9) == 0);
            rempty = ($urandom_range(0, 9) == 0);
            #2;
            vdrv = konst ? m_g : 2'b00;
            ex_u = (v_thru && !uempty) ? (din | vdrv) : 2'b00;
            ex_d = (v_thru && !dempty) ? (uin | vdrv) : 2'b00;
            ex_l = lempty ? 2'b00 : h_thru ? rin : gate_h ? m_g : 2'b00;
            ex_r = rempty ? 2'b00 : h_thru ? lin : gate_h ? m_g : 2'b00;
            check_all($sformatf("rand_c%0d_k%0d", c, k), ex_u, ex_d, ex_l, ex_r,
                      !(h_thru || gate_h || konst), !v_thru);
            check("rand.cbitout", 8'(cbitout), 8'(c[2]));
            tick();
            hin  = lin | rin;
            vin  = uin | din;
            ok_h = (hin == 2'b01) || (hin == 2'b10);
            m = (c == 3'd6) ? (vin == 2'b10 && ok_h) :
                (c == 3'd7) ? (vin == 2'b01 && ok_h) : (konst && ok_h);
            if (!m_busy) begin
                if (hin != 2'b00 && m) begin
                    m_busy = 1'b1;
                    m_g = (c == 3'd4) ? 2'b10 : (c == 3'd5) ? 2'b01 : hin;
                end
            end else if (hin == 2'b00) begin
                m_busy = 1'b0;
                m_g    = 2'b00;
            end else begin
                m_g = (c == 3'd4) ? 2'b10 : (c == 3'd5) ? 2'b01 : hin;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = '{3'b000, 4'b0000, 2'b10, 2'b01, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1};
        vecs[1]  = '{3'b001, 4'b0000, 2'b10, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b01, 1'b0, 1'b0};
        vecs[2]  = '{3'b001, 4'b1010, 2'b10, 2'b01, 2'b01, 2'b10, 2'b00, 2'b10, 2'b00, 2'b01, 1'b0, 1'b0};
        vecs[3]  = '{3'b010, 4'b0000, 2'b10, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0, 1'b1};
        vecs[4]  = '{3'b010, 4'b0001, 2'b10, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1};
        vecs[5]  = '{3'b011, 4'b0000, 2'b10, 2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 1'b1, 1'b0};
        vecs[6]  = '{3'b011, 4'b0100, 2'b10, 2'b01, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
        vecs[7]  = '{3'b001, 4'b0000, 2'b11, 2'b00, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00, 2'b11, 1'b0, 1'b0};
        vecs[8]  = '{3'b001, 4'b0000, 2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0};
        vecs[9]  = '{3'b110, 4'b0000, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0};
        vecs[10] = '{3'b100, 4'b0000, 2'b01, 2'b10, 2'b00, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0};
        vecs[11] = '{3'b111, 4'b0000, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0};

        // Reset with active inputs
        reset = 1'b1; confclk = 1'b1; cbitin = 1'b1;
        uin = 2'b10; din = 2'b01; lin = 2'b10; rin = 2'b01;
        uempty = 1'b0; dempty = 1'b0; lempty = 1'b0; rempty = 1'b0;
        tick(); tick();
        check_all("reset", 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1);
        check("reset.cbitout", 8'(cbitout), 8'd0);
        reset = 1'b0; confclk = 1'b0; cbitin = 1'b0;
        null_inputs();
        tick();

        // Combinational vector table
        for (int i = 0; i < 12; i++) begin
            shift_cfg(vecs[i].cfg);
            {uempty, dempty, lempty, rempty} = vecs[i].emp;
            uin = vecs[i].ui; din = vecs[i].di; lin = vecs[i].li; rin = vecs[i].ri;
            #2;
            check_all($sformatf("vec%0d", i), vecs[i].xu, vecs[i].xd, vecs[i].xl,
                      vecs[i].xr, vecs[i].xh, vecs[i].xv);
        end

        // '|' loaded bit by bit; confclk low must hold the config
        shift_cfg(3'b011);
        cbitin = 1'b1; tick();
        check("vbar.hempty", 8'(hempty), 8'd1);
        check("vbar.vempty", 8'(vempty), 8'd0);
        uin = 2'b10; din = 2'b01; lin = 2'b10; #2;
        check("vbar.dout", 8'(dout), 8'(2'b10));
        check("vbar.uout", 8'(uout), 8'(2'b01));
        check("vbar.rout", 8'(rout), 8'(2'b00));

        // '-' with right neighbour empty then present
        shift_cfg(3'b010);
        uin = 2'b10; lin = 2'b01; rempty = 1'b1; #2;
        check("hbar.rout_empty", 8'(rout), 8'(2'b00));
        rempty = 1'b0; #2;
        check("hbar.rout", 8'(rout), 8'(2'b01));
        check("hbar.uout", 8'(uout), 8'(2'b00));
        check("hbar.dout", 8'(dout), 8'(2'b00));

        // 'Y': one clock latency, hold through vin change, release on null
        shift_cfg(3'b110);
        uin = 2'b10; lin = 2'b01; #2;
        check("y.rout_pre", 8'(rout), 8'(2'b00));
        tick();
        check("y.rout", 8'(rout), 8'(2'b01));
        check("y.lout", 8'(lout), 8'(2'b01));
        uin = 2'b01; tick();
        check("y.rout_hold", 8'(rout), 8'(2'b01));
        lin = 2'b00; #2;
        check("y.rout_until_edge", 8'(rout), 8'(2'b01));
        tick();
        check("y.rout_release", 8'(rout), 8'(2'b00));

        // 'N': no match on vin=1, match on vin=0
        shift_cfg(3'b111);
        uin = 2'b10; lin = 2'b10; tick(); tick();
        check("n.rout_nomatch", 8'(rout), 8'(2'b00));
        uin = 2'b01; tick();
        check("n.rout", 8'(rout), 8'(2'b10));
        check("n.lout", 8'(lout), 8'(2'b10));

        // 'N' with illegal horizontal input never matches
        shift_cfg(3'b111);
        uin = 2'b01; lin = 2'b11; tick(); tick();
        check("n.rout_bad", 8'(rout), 8'(2'b00));

        // '1': constant on the vertical, then config chain replay
        shift_cfg(3'b100);
        lin = 2'b01; tick();
        check("one.dout", 8'(dout), 8'(2'b10));
        check("one.uout", 8'(uout), 8'(2'b10));
        lin = 2'b00; tick();
        check("one.dout_rel", 8'(dout), 8'(2'b00));
        check("one.uout_rel", 8'(uout), 8'(2'b00));
        check("chain.bit0", 8'(cbitout), 8'd1);
        confclk = 1'b1; cbitin = 1'b1;
        tick(); check("chain.bit1", 8'(cbitout), 8'd0);
        tick(); check("chain.bit2", 8'(cbitout), 8'd0);
        tick(); check("chain.new", 8'(cbitout), 8'd1);
        confclk = 1'b0; cbitin = 1'b0;

        // Reset mid-operation on a crossing
        shift_cfg(3'b001);
        uin = 2'b10; din = 2'b01; lin = 2'b01; rin = 2'b10; #2;
        check("mid.dout_pre", 8'(dout), 8'(2'b10));
        reset = 1'b1; tick();
        check_all("mid_reset", 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1);
        check("mid_reset.cbitout", 8'(cbitout), 8'd0);
        reset = 1'b0;

        // Randomized stimulus against the model
        for (int b = 0; b < 16; b++) begin
            random_block(3'(b % 8), 40);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
